// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LS chunk first,
// with valid/ready handshakes and carry/overflow flags.
module chunk_adder #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] work_nxt;
  logic             last;
  logic             msb_cin;
  logic             fin_c;
  logic             fin_ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);

  assign csum = {1'b0, a_r[CHUNK-1:0]}
              + {1'b0, b_r[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry};

  // Result chunks enter at the top and shift down, so the
  // LS chunk lands at bit 0 after N steps.
  assign work_nxt = (work >> CHUNK)
                  | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign fin_c   = csum[CHUNK];
  assign msb_cin = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ csum[CHUNK-1];
  assign fin_ovf = SIGNED ? (msb_cin ^ fin_c)
                          : (sub_r ? ~fin_c : fin_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      work  <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | c_in;
            sub_r <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        state == RUN: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          carry <= fin_c;
          work  <= work_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= work_nxt;
            c_out <= fin_c;
            ovf   <= fin_ovf;
            cnt   <= '0;
            state <= DONE;
          end
        end
        state == DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
